// File: rtl/hazard_scoreboard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_pkg
// Shared constants for the hazard controller of the 5-stage core:
//   - RV32/RV64 major opcodes seen by the D-stage decoder
//   - result-source encoding used to recognise a load in E
//   - forwarding-mux select encodings (FWD_RF / FWD_W / FWD_M)
//   - opcode classification helpers (rs1 used, rs2 used, writes rd)
// -----------------------------------------------------------------------------
package hazard_scoreboard_unit_pkg;

  localparam int OP_BITS       = 7;
  localparam int RSLT_SRC_BITS = 2;
  localparam int DATA_BITS     = 32;
  localparam int FWD_BITS      = 2;

  typedef enum logic [OP_BITS-1:0] {
    OPC_LOAD      = 7'b0000011,
    OPC_OP_IMM    = 7'b0010011,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_STORE     = 7'b0100011,
    OPC_OP        = 7'b0110011,
    OPC_LUI       = 7'b0110111,
    OPC_OP_32     = 7'b0111011,
    OPC_BRANCH    = 7'b1100011,
    OPC_JALR      = 7'b1100111,
    OPC_JAL       = 7'b1101111,
    OPC_SYSTEM    = 7'b1110011
  } opcode_e;

  // Result source selecting the data-memory read in W.
  localparam logic [RSLT_SRC_BITS-1:0] RSLT_SRC_LOAD = 2'b01;

  // Register x0.
  localparam int REG_ZERO = 0;

  typedef enum logic [FWD_BITS-1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  function automatic logic op_uses_rs1(input logic [OP_BITS-1:0] op);
    logic used;
    used = 1'b0;
    case (op)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32: used = 1'b1;
      default:                                      used = 1'b0;
    endcase
    return used;
  endfunction

  function automatic logic op_uses_rs2(input logic [OP_BITS-1:0] op);
    logic used;
    used = 1'b0;
    case (op)
      OPC_BRANCH, OPC_STORE, OPC_OP, OPC_OP_32: used = 1'b1;
      default:                                  used = 1'b0;
    endcase
    return used;
  endfunction

  // Opcodes that write rd; used for the WAW check against an outstanding MDU result.
  function automatic logic op_writes_rd(input logic [OP_BITS-1:0] op);
    logic wr;
    wr = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
      OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32, OPC_SYSTEM: wr = 1'b1;
      default:                                                  wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit_reg_scoreboard
// Per-register pending bit vector for results still owed by the multi-cycle
// MUL/DIV unit, plus a busy flag for the unit itself.
// Ports:
//   i_clk, i_reset        clock, synchronous active-low reset
//   i_set, i_set_addr     mark a register pending (x0 is never marked)
//   i_clr, i_clr_addr     writeback of a pending register
//   i_busy_set/_clr       MDU issue / MDU completion
//   i_rd_addr[N_READ]     lookup addresses
//   o_pend_eff[N_READ]    pending and not written back in this same cycle
//   o_busy                an MDU op is outstanding
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit_reg_scoreboard #(
  parameter int ADDR_BITS = 5,
  parameter int N_READ    = 3
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_set,
  input  logic [ADDR_BITS-1:0]              i_set_addr,
  input  logic                              i_clr,
  input  logic [ADDR_BITS-1:0]              i_clr_addr,
  input  logic                              i_busy_set,
  input  logic                              i_busy_clr,
  input  logic [N_READ-1:0][ADDR_BITS-1:0]  i_rd_addr,
  output logic [N_READ-1:0]                 o_pend_eff,
  output logic                              o_busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DEPTH-1:0] r_sb;
  logic [DEPTH-1:0] w_sb_next;
  logic             r_busy;
  logic             w_busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        // x0 never holds a pending result.
        assign w_sb_next[gi] = 1'b0;
      end else begin : g_bit
        logic w_set_hit;
        logic w_clr_hit;
        assign w_set_hit = i_set & (i_set_addr == ADDR_BITS'(gi));
        assign w_clr_hit = i_clr & (i_clr_addr == ADDR_BITS'(gi));
        // Set has priority: a new producer for the same register issued
        // in the cycle the old one writes back stays pending.
        assign w_sb_next[gi] = w_set_hit | (r_sb[gi] & ~w_clr_hit);
      end
    end

    for (gi = 0; gi < N_READ; gi++) begin : g_read
      // The register file is write-first, so a writeback in this cycle is
      // already visible to D and must not stall it.
      assign o_pend_eff[gi] = r_sb[i_rd_addr[gi]] &
                              ~(i_clr & (i_clr_addr == i_rd_addr[gi]));
    end
  endgenerate

  assign w_busy_next = i_busy_set | (r_busy & ~i_busy_clr);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sb   <= '0;
      r_busy <= 1'b0;
    end else begin
      r_sb   <= w_sb_next;
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Hazard controller for the 5-stage core: load-use stall, MDU scoreboard
// stall, optional E-stage forwarding from M/W, branch-prediction check and
// saturating stall/flush performance counters.
// Parameters:
//   REG_ADDR_BITS  register address width
//   FORWARDING     1: forward from M/W; 0: stall D while a producer is in E/M
//   CNT_BITS       performance counter width (saturating)
// Ports:
//   i_clk, i_reset                 clock, synchronous active-low reset
//   i_opD, i_mduOpD                D-stage opcode / D holds an MDU op
//   i_readRegister1D/2D, i_writeRegD, i_readRegister1E/2E, i_writeRegE,
//   i_writeRegM, i_writeRegW       register addresses per stage
//   i_regWriteE/M/W                stage writes its destination
//   i_resultSrcE, i_csrrs          E-stage result source / E is CSRRS
//   i_PCD, i_PCNextE, i_bubble     prediction check inputs
//   i_mduIssueE, i_mduDoneW, i_mduRdW  MDU issue / writeback
//   o_PCSrc, o_stallF, o_stallD, o_flushD, o_flushE  pipeline control
//   o_forwardAE, o_forwardBE       forwarding selects (00 RF, 01 W, 10 M)
//   o_mduBusy                      MDU op outstanding
//   o_stallCount, o_flushCount     performance counters
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int REG_ADDR_BITS = 5,
  parameter int FORWARDING    = 1,
  parameter int CNT_BITS      = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [OP_BITS-1:0]       i_opD,
  input  logic                     i_mduOpD,
  input  logic [REG_ADDR_BITS-1:0] i_readRegister1D,
  input  logic [REG_ADDR_BITS-1:0] i_readRegister2D,
  input  logic [REG_ADDR_BITS-1:0] i_writeRegD,
  input  logic [REG_ADDR_BITS-1:0] i_readRegister1E,
  input  logic [REG_ADDR_BITS-1:0] i_readRegister2E,
  input  logic [REG_ADDR_BITS-1:0] i_writeRegE,
  input  logic [REG_ADDR_BITS-1:0] i_writeRegM,
  input  logic [REG_ADDR_BITS-1:0] i_writeRegW,
  input  logic                     i_regWriteE,
  input  logic                     i_regWriteM,
  input  logic                     i_regWriteW,
  input  logic [RSLT_SRC_BITS-1:0] i_resultSrcE,
  input  logic                     i_csrrs,
  input  logic [DATA_BITS-1:0]     i_PCD,
  input  logic [DATA_BITS-1:0]     i_PCNextE,
  input  logic                     i_bubble,
  input  logic                     i_mduIssueE,
  input  logic                     i_mduDoneW,
  input  logic [REG_ADDR_BITS-1:0] i_mduRdW,
  output logic                     o_PCSrc,
  output logic                     o_stallF,
  output logic                     o_stallD,
  output logic                     o_flushD,
  output logic                     o_flushE,
  output logic [FWD_BITS-1:0]      o_forwardAE,
  output logic [FWD_BITS-1:0]      o_forwardBE,
  output logic                     o_mduBusy,
  output logic [CNT_BITS-1:0]      o_stallCount,
  output logic [CNT_BITS-1:0]      o_flushCount
);

  localparam logic FWD_EN = (FORWARDING != 0);

  // ---------------------------------------------------------------------------
  // D-stage operand classification
  // ---------------------------------------------------------------------------
  logic w_reg_write_d;
  logic [1:0]                    w_rs_used;
  logic [1:0][REG_ADDR_BITS-1:0] w_rs_d;
  logic [1:0][REG_ADDR_BITS-1:0] w_rs_e;

  assign w_reg_write_d = op_writes_rd(i_opD);
  assign w_rs_used     = {op_uses_rs2(i_opD), op_uses_rs1(i_opD)};
  assign w_rs_d        = {i_readRegister2D, i_readRegister1D};
  assign w_rs_e        = {i_readRegister2E, i_readRegister1E};

  // ---------------------------------------------------------------------------
  // MDU scoreboard: lookups 0/1 = rs1D/rs2D, 2 = rdD (WAW)
  // ---------------------------------------------------------------------------
  logic [2:0]                    w_pend_eff;
  logic [2:0][REG_ADDR_BITS-1:0] w_sb_rd_addr;
  logic                          w_mdu_busy;
  logic                          w_sb_set;

  assign w_sb_rd_addr = {i_writeRegD, i_readRegister2D, i_readRegister1D};
  assign w_sb_set     = i_mduIssueE & (i_writeRegE != REG_ADDR_BITS'(REG_ZERO));

  hazard_scoreboard_unit_reg_scoreboard #(
    .ADDR_BITS (REG_ADDR_BITS),
    .N_READ    (3)
  ) u_reg_scoreboard (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set      (w_sb_set),
    .i_set_addr (i_writeRegE),
    .i_clr      (i_mduDoneW),
    .i_clr_addr (i_mduRdW),
    .i_busy_set (i_mduIssueE),
    .i_busy_clr (i_mduDoneW),
    .i_rd_addr  (w_sb_rd_addr),
    .o_pend_eff (w_pend_eff),
    .o_busy     (w_mdu_busy)
  );

  logic w_sb_stall;
  // A second MDU op waits for the unit, except in the cycle the unit retires.
  assign w_sb_stall = (w_rs_used[0] & w_pend_eff[0]) |
                      (w_rs_used[1] & w_pend_eff[1]) |
                      (w_reg_write_d & w_pend_eff[2]) |
                      (i_mduOpD & w_mdu_busy & ~i_mduDoneW);

  // ---------------------------------------------------------------------------
  // Per-operand dependency and forwarding logic
  // ---------------------------------------------------------------------------
  logic [1:0] w_hit_e;        // used D source matches rdE (rdE != 0)
  logic [1:0] w_live_hit;     // used D source matches a writing E or M
  logic [1:0] w_fwd_m;
  logic [1:0] w_fwd_w;
  logic [1:0][FWD_BITS-1:0] w_fwd_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic w_rs_d_nz;
      logic w_rs_e_nz;
      assign w_rs_d_nz = (w_rs_d[gi] != REG_ADDR_BITS'(REG_ZERO));
      assign w_rs_e_nz = (w_rs_e[gi] != REG_ADDR_BITS'(REG_ZERO));

      assign w_hit_e[gi]    = w_rs_used[gi] & w_rs_d_nz & (w_rs_d[gi] == i_writeRegE);
      assign w_live_hit[gi] = w_rs_used[gi] & w_rs_d_nz &
                              ((i_regWriteE & (w_rs_d[gi] == i_writeRegE)) |
                               (i_regWriteM & (w_rs_d[gi] == i_writeRegM)));

      assign w_fwd_m[gi] = i_regWriteM & w_rs_e_nz & (w_rs_e[gi] == i_writeRegM);
      assign w_fwd_w[gi] = i_regWriteW & w_rs_e_nz & (w_rs_e[gi] == i_writeRegW);
      // M is the younger producer and wins over W.
      assign w_fwd_sel[gi] = w_fwd_m[gi] ? FWD_M : (w_fwd_w[gi] ? FWD_W : FWD_RF);
    end
  endgenerate

  logic w_load_stall;
  logic w_nofwd_stall;

  assign w_load_stall  = FWD_EN & (i_resultSrcE == RSLT_SRC_LOAD) & (|w_hit_e);
  // Without forwarding the producer must reach W, where the write-first RF
  // supplies the value; the rs2 term is ignored while E holds CSRRS.
  assign w_nofwd_stall = ~FWD_EN & (w_live_hit[0] | (w_live_hit[1] & ~i_csrrs));

  assign o_forwardAE = FWD_EN ? w_fwd_sel[0] : FWD_RF;
  assign o_forwardBE = (FWD_EN & ~i_csrrs) ? w_fwd_sel[1] : FWD_RF;

  // ---------------------------------------------------------------------------
  // Prediction check and stall/flush control
  // ---------------------------------------------------------------------------
  logic w_valid_pred;
  logic w_stall;
  logic w_stall_d;
  logic w_flush_d;

  assign w_valid_pred = (i_PCD == i_PCNextE) | i_bubble;
  assign w_stall      = w_load_stall | w_nofwd_stall | w_sb_stall;
  // A misprediction discards D anyway, so it overrides any stall.
  assign w_stall_d    = w_stall & w_valid_pred;
  assign w_flush_d    = ~w_valid_pred;

  assign o_PCSrc   = w_valid_pred;
  assign o_stallF  = w_stall_d;
  assign o_stallD  = w_stall_d;
  assign o_flushD  = w_flush_d;
  assign o_flushE  = w_stall | ~w_valid_pred;
  assign o_mduBusy = w_mdu_busy;

  // ---------------------------------------------------------------------------
  // Saturating performance counters: 0 = stall cycles, 1 = flush cycles
  // ---------------------------------------------------------------------------
  logic [1:0]               w_cnt_inc;
  logic [1:0][CNT_BITS-1:0] w_count;

  assign w_cnt_inc = {w_flush_d, w_stall_d};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_BITS-1:0] r_count;
      logic [CNT_BITS-1:0] w_count_next;

      always_comb begin
        w_count_next = r_count;
        if (w_cnt_inc[gi] && (r_count != {CNT_BITS{1'b1}})) begin
          w_count_next = r_count + CNT_BITS'(1);
        end
      end

      always_ff @(posedge i_clk) begin
        if (!i_reset) begin
          r_count <= '0;
        end else begin
          r_count <= w_count_next;
        end
      end

      assign w_count[gi] = r_count;
    end
  endgenerate

  assign o_stallCount = w_count[0];
  assign o_flushCount = w_count[1];

endmodule
